instruction_memory_prog: RTL and testbench

- Parametrised, runtime-programmable successor to the fixed-program instruction memory.
- Clears its array through a reset sweep state machine, then accepts program words over a valid/ready load port.
- Serves byte-addressed instruction fetches with a registered, one-cycle read.
- Flags misaligned and out-of-range accesses; sits between the PC/fetch stage and the core, with the load port driven by the testbench or boot loader.

---
 rtl/imem_pkg.sv | 30 +++
 rtl/imem_ram.sv | 27 ++
 rtl/instruction_memory_prog.sv | 131 +++++++++++++
 tb/tb_instruction_memory_prog.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the programmable instruction memory.
package imem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } imem_state_t;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // Addresses are zero-extended to this width before checking, so the
  // range compare never truncates the caller's upper address bits.
  localparam int CHK_ADDR_W = 64;

  typedef struct packed {
    logic                  aligned;
    logic                  in_range;
    logic [CHK_ADDR_W-3:0] idx;
  } addr_chk_t;

  function automatic addr_chk_t addr_check(input logic [CHK_ADDR_W-1:0] addr,
                                           input int unsigned           depth);
    addr_chk_t r;
    r.aligned  = (addr[1:0] == 2'b00);
    r.idx      = addr[CHK_ADDR_W-1:2];
    r.in_range = (r.idx < (CHK_ADDR_W-2)'(depth));
    return r;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Single write port, single registered read port; a read and a write to the
// same index in one cycle returns the old word (read-before-write).
module imem_ram
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and registered read share the edge, so the read sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instruction_memory_prog.sv
// Runtime-programmable instruction memory: clear sweep after reset, then
// serves one-cycle fetches and accepts program writes.
//
// state | meaning
// CLEAR | sweeping NOP_WORD into every word, ports not ready
// RUN   | fetch and program ports open, terminal until reset
module instruction_memory_prog
  import imem_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 64,
  parameter int                 ADDR_W   = 32,
  parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(NOP_WORD_DEFAULT),
  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_fault,
  input  logic              prog_valid,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_err,
  output logic              init_done,
  output logic [IDX_W:0]    prog_count
);

  localparam int CNT_W = IDX_W + 1;

  imem_state_t       state;
  logic [IDX_W-1:0]  clr_idx;
  addr_chk_t         f_chk;
  addr_chk_t         p_chk;
  logic              fetch_acc;
  logic              fetch_ok;
  logic              prog_acc;
  logic              prog_ok;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              out_nop;
  logic              unused_idx_bits;

  assign f_chk     = addr_check(CHK_ADDR_W'(fetch_addr), DEPTH);
  assign p_chk     = addr_check(CHK_ADDR_W'(prog_addr), DEPTH);
  assign fetch_acc = fetch_req && fetch_ready;
  assign fetch_ok  = f_chk.aligned && f_chk.in_range;
  assign prog_acc  = prog_valid && prog_ready;
  assign prog_ok   = p_chk.aligned && p_chk.in_range;

  // Only the low index bits address the array once in_range has passed.
  assign unused_idx_bits = ^{f_chk.idx[CHK_ADDR_W-3:IDX_W], p_chk.idx[CHK_ADDR_W-3:IDX_W]};

  // The clear sweep owns the write port in CLEAR, the program port in RUN.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clr_idx;
    ram_wdata = NOP_WORD;
    if (state == CLEAR) begin
      ram_we = 1'b1;
    end else if (prog_acc && prog_ok) begin
      ram_we    = 1'b1;
      ram_waddr = p_chk.idx[IDX_W-1:0];
      ram_wdata = prog_data;
    end
  end

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (fetch_acc && fetch_ok),
    .raddr (f_chk.idx[IDX_W-1:0]),
    .rdata (ram_rdata)
  );

  // Faulted fetches and the reset state present NOP_WORD instead of RAM data.
  assign instr_out = out_nop ? NOP_WORD : ram_rdata;

  // Sequencer: clear sweep, then fetch/program bookkeeping with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLEAR;
      clr_idx     <= '0;
      instr_valid <= 1'b0;
      out_nop     <= 1'b1;
      instr_fault <= 1'b0;
      prog_err    <= 1'b0;
      init_done   <= 1'b0;
      prog_count  <= '0;
      fetch_ready <= 1'b0;
      prog_ready  <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + IDX_W'(1);
          if (clr_idx == IDX_W'(DEPTH - 1)) begin
            state       <= RUN;
            clr_idx     <= '0;
            init_done   <= 1'b1;
            fetch_ready <= 1'b1;
            prog_ready  <= 1'b1;
          end
        end
        RUN: begin
          instr_valid <= fetch_acc;
          if (fetch_acc) begin
            instr_fault <= !fetch_ok;
            out_nop     <= !fetch_ok;
          end
          prog_err <= prog_acc && !prog_ok;
          if (prog_acc && prog_ok && (prog_count != CNT_W'(DEPTH)))
            prog_count <= prog_count + CNT_W'(1);
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_memory_prog.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// word-array reference model of the instruction memory.
module tb_instruction_memory_prog;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int D  = 64;
  localparam int D4 = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ready;
  logic          instr_valid;
  logic [DW-1:0] instr_out;
  logic          instr_fault;
  logic          prog_valid;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic          prog_ready;
  logic          prog_err;
  logic          init_done;
  logic [6:0]    prog_count;

  logic          f4_req;
  logic [AW-1:0] f4_addr;
  logic          f4_ready;
  logic          iv4;
  logic [DW-1:0] io4;
  logic          if4;
  logic          p4_valid;
  logic [AW-1:0] p4_addr;
  logic [DW-1:0] p4_data;
  logic          p4_ready;
  logic          p4_err;
  logic          id4;
  logic [2:0]    cnt4;

  instruction_memory_prog #(.DATA_W(DW), .DEPTH(D), .ADDR_W(AW), .NOP_WORD(32'h0)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_fault(instr_fault),
    .prog_valid(prog_valid), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_ready(prog_ready), .prog_err(prog_err), .init_done(init_done),
    .prog_count(prog_count)
  );

  instruction_memory_prog #(.DATA_W(DW), .DEPTH(D4), .ADDR_W(AW), .NOP_WORD(32'h0)) dut4 (
    .clk(clk), .reset(reset),
    .fetch_req(f4_req), .fetch_addr(f4_addr), .fetch_ready(f4_ready),
    .instr_valid(iv4), .instr_out(io4), .instr_fault(if4),
    .prog_valid(p4_valid), .prog_addr(p4_addr), .prog_data(p4_data),
    .prog_ready(p4_ready), .prog_err(p4_err), .init_done(id4),
    .prog_count(cnt4)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ref_mem [D];
  int          ref_count;
  logic [31:0] last_out;
  logic        last_fault;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> 2) < 32'(D));
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_ok(a)) return ref_mem[a >> 2];
    return 32'h0;
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < D; i++) ref_mem[i] = 32'h0;
    ref_count = 0;
  endtask

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
    if (ref_ok(a)) begin
      ref_mem[a >> 2] = d;
      if (ref_count < D) ref_count++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] a, input string tag);
    last_out   = ref_read(a);
    last_fault = !ref_ok(a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    cyc();
    fetch_req = 1'b0;
    chk({tag, ".valid"}, instr_valid, 1);
    chk({tag, ".fault"}, instr_fault, last_fault);
    chk({tag, ".data"}, instr_out, last_out);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input string tag);
    ref_write(a, d);
    prog_valid = 1'b1;
    prog_addr  = a;
    prog_data  = d;
    cyc();
    prog_valid = 1'b0;
    chk({tag, ".err"}, prog_err, !ref_ok(a));
    chk({tag, ".count"}, prog_count, ref_count);
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!init_done && n < 200) begin
      cyc();
      n++;
    end
    chk(tag, n, D);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 71)) << 2;
    if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
    if ($urandom_range(0, 19) == 0) a[31] = 1'b1;
    return a;
  endfunction

  initial begin
    logic        fr, pv;
    logic [31:0] fa, pa, pd;
    logic [31:0] exp_f;
    int          exp_sat;

    fetch_req = 0; fetch_addr = 0; prog_valid = 0; prog_addr = 0; prog_data = 0;
    f4_req = 0; f4_addr = 0; p4_valid = 0; p4_addr = 0; p4_data = 0;
    last_out = 0; last_fault = 0;
    ref_clear();

    reset = 1'b1;
    cyc();
    cyc();
    chk("rst.valid", instr_valid, 0);
    chk("rst.out", instr_out, 0);
    chk("rst.fault", instr_fault, 0);
    chk("rst.init_done", init_done, 0);
    chk("rst.fetch_ready", fetch_ready, 0);
    chk("rst.prog_ready", prog_ready, 0);
    chk("rst.prog_count", prog_count, 0);
    chk("rst.prog_err", prog_err, 0);

    reset = 1'b0;
    fetch_req = 1'b1;
    prog_valid = 1'b1;
    prog_addr = 32'h8;
    prog_data = 32'hDEAD_BEEF;
    cyc();
    chk("clear.ignore_fetch", instr_valid, 0);
    fetch_req = 1'b0;
    prog_valid = 1'b0;
    begin
      int n;
      n = 1;
      while (!init_done && n < 200) begin
        cyc();
        n++;
      end
      chk("sweep_len", n, D);
    end
    chk("run.fetch_ready", fetch_ready, 1);
    chk("run.prog_ready", prog_ready, 1);
    chk("run.count_zero", prog_count, 0);

    do_fetch(32'h0, "clr0");
    do_fetch(32'h4, "clr4");
    do_fetch(32'h8, "clr8");
    do_fetch(32'hFC, "clrFC");

    do_write(32'h4, 32'h0273_4820, "wr4");
    do_write(32'h10, 32'h8D28_0000, "wr10");
    fetch_req = 1'b1;
    fetch_addr = 32'h4;
    cyc();
    chk("b2b.first", instr_out, 32'h0273_4820);
    chk("b2b.first_valid", instr_valid, 1);
    fetch_addr = 32'h10;
    cyc();
    chk("b2b.second", instr_out, 32'h8D28_0000);
    chk("b2b.second_valid", instr_valid, 1);
    fetch_req = 1'b0;
    last_out = 32'h8D28_0000;
    last_fault = 1'b0;
    cyc();
    chk("b2b.idle_valid", instr_valid, 0);
    chk("b2b.hold_out", instr_out, 32'h8D28_0000);
    chk("b2b.count", prog_count, 2);

    do_fetch(32'h6, "flt_misalign");
    do_fetch(32'h100, "flt_range");
    do_fetch(32'h4000_0004, "flt_wide");
    do_write(32'h102, 32'h1234_5678, "wr_bad");
    cyc();
    chk("wr_bad.pulse_end", prog_err, 0);
    chk("wr_bad.count_kept", prog_count, 2);
    do_fetch(32'h100, "flt_range_again");

    do_write(32'h14, 32'hAAAA_0000, "coll_setup");
    prog_valid = 1'b1; prog_addr = 32'h14; prog_data = 32'h5555_0000;
    fetch_req = 1'b1; fetch_addr = 32'h14;
    last_out = ref_read(32'h14);
    last_fault = 1'b0;
    ref_write(32'h14, 32'h5555_0000);
    cyc();
    prog_valid = 1'b0;
    fetch_req = 1'b0;
    chk("coll.old", instr_out, 32'hAAAA_0000);
    do_fetch(32'h14, "coll.new");

    exp_sat = 0;
    for (int i = 0; i < 6; i++) begin
      p4_valid = 1'b1;
      p4_addr  = 32'((i % 4) * 4);
      p4_data  = $urandom;
      cyc();
      p4_valid = 1'b0;
      if (exp_sat < D4) exp_sat++;
      chk("sat.count", cnt4, exp_sat);
      chk("sat.err", p4_err, 0);
    end
    chk("sat.final", cnt4, 4);

    for (int c = 0; c < 400; c++) begin
      fr = 1'($urandom_range(0, 1));
      pv = 1'($urandom_range(0, 1));
      fa = rand_addr();
      pa = rand_addr();
      if ($urandom_range(0, 3) == 0) pa = fa;
      pd = $urandom;
      if (fr) begin
        last_out   = ref_read(fa);
        last_fault = !ref_ok(fa);
      end
      if (pv) ref_write(pa, pd);
      fetch_req = fr; fetch_addr = fa;
      prog_valid = pv; prog_addr = pa; prog_data = pd;
      cyc();
      chk("rnd.valid", instr_valid, fr);
      chk("rnd.data", instr_out, last_out);
      chk("rnd.fault", instr_fault, last_fault);
      chk("rnd.err", prog_err, pv && !ref_ok(pa));
      chk("rnd.count", prog_count, ref_count);
    end
    fetch_req = 1'b0;
    prog_valid = 1'b0;

    do_write(32'h4, 32'h1357_9BDF, "mid_wr");
    fetch_req = 1'b1;
    fetch_addr = 32'h4;
    cyc();
    exp_f = 32'h1357_9BDF;
    chk("mid.stream", instr_out, exp_f);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    fetch_req = 1'b0;
    chk("mid.valid", instr_valid, 0);
    chk("mid.init_done", init_done, 0);
    chk("mid.count", prog_count, 0);
    chk("mid.out", instr_out, 0);
    ref_clear();
    wait_init("mid.sweep_len");
    do_fetch(32'h4, "mid.recleared");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
